toggle_rx: RTL and testbench

TOGGLE_RX -- requirements
Module: toggle_rx

---
 rtl/toggle_rx.sv | 106 ++++++++++
 tb/tb_toggle_rx.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/toggle_rx.sv
// Toggle-handshake receiver with a 2-entry output FIFO.
// Define TOGGLE_RX_SYNC_EN to pass t_in through a 2-flop synchronizer.
module toggle_rx (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       t_in,
  input  logic [7:0] data_in,
  output logic       ack_t,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] out_data,
  output logic [7:0] evt_count,
  output logic       overrun
);

  logic t_s;

`ifdef TOGGLE_RX_SYNC_EN
  logic s1;
  logic s2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
    end else begin
      s1 <= t_in;
      s2 <= s1;
    end
  end

  assign t_s = s2;
`else
  assign t_s = t_in;
`endif

  logic [1:0] cnt;
  logic [7:0] tail;
  logic       trk;
  logic       armed;
  logic       pending;
  logic       pop;
  logic       accept;

  assign pending   = (t_s != ack_t);
  assign out_valid = (cnt != 2'd0);
  assign pop       = out_valid & out_ready;
  assign accept    = pending & ((cnt != 2'd2) | pop);

  // armed: a request was pending last edge and is still unacked
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ack_t     <= 1'b0;
      evt_count <= 8'h00;
      overrun   <= 1'b0;
      trk       <= 1'b0;
      armed     <= 1'b0;
    end else begin
      ack_t     <= ack_t ^ accept;
      evt_count <= evt_count + {7'd0, accept};
      armed     <= pending & ~accept;
      if (pending)
        trk <= t_s;
      if (armed && (t_s != trk))
        overrun <= 1'b1;
    end
  end

  // out_data is the head register; tail holds the second word
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt      <= 2'd0;
      out_data <= 8'h00;
      tail     <= 8'h00;
    end else begin
      unique case (1'b1)
        (cnt == 2'd0): begin
          if (accept) begin
            out_data <= data_in;
            cnt      <= 2'd1;
          end
        end
        (cnt == 2'd1): begin
          if (accept && pop) begin
            out_data <= data_in;
          end else if (accept) begin
            tail <= data_in;
            cnt  <= 2'd2;
          end else if (pop) begin
            cnt <= 2'd0;
          end
        end
        default: begin
          if (pop) begin
            out_data <= tail;
            if (accept)
              tail <= data_in;
            else
              cnt <= 2'd1;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_toggle_rx.sv
// Directed bench for toggle_rx with a scoreboard on popped words.
// Latency follows TOGGLE_RX_SYNC_EN.
module tb_toggle_rx;

`ifdef TOGGLE_RX_SYNC_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       t_in = 1'b0;
  logic [7:0] data_in = 8'h00;
  logic       ack_t;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [7:0] out_data;
  logic [7:0] evt_count;
  logic       overrun;

  int tests = 0;
  int fails = 0;
  logic [7:0] exp_q[$];

  toggle_rx dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .t_in      (t_in),
    .data_in   (data_in),
    .ack_t     (ack_t),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .evt_count (evt_count),
    .overrun   (overrun)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [7:0] got,
                     input logic [7:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ack();
    int n = 0;
    while (ack_t !== t_in && n < 20) begin
      tick();
      n++;
    end
    chk("ack_wait", {7'd0, ack_t}, {7'd0, t_in});
  endtask

  task automatic send(input logic [7:0] d);
    data_in = d;
    t_in = ~t_in;
    wait_ack();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    t_in = 1'b0;
    exp_q.delete();
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  // a pop happens at the next posedge when valid & ready here
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        chk("pop_unexpected", out_data, 8'hxx);
      end else begin
        chk("pop_data", out_data, exp_q.pop_front());
      end
    end
  end

  initial begin
    logic t_prev;

    do_reset();
    chk("rst_ack", {7'd0, ack_t}, 8'd0);
    chk("rst_valid", {7'd0, out_valid}, 8'd0);
    chk("rst_ovr", {7'd0, overrun}, 8'd0);
    chk("rst_data", out_data, 8'h00);
    chk("rst_evt", evt_count, 8'h00);

    // single word
    out_ready = 1'b1;
    exp_q.push_back(8'hA5);
    data_in = 8'hA5;
    t_in = 1'b1;
    repeat (LAT) tick();
    chk("sw_ack_pre", {7'd0, ack_t}, 8'd0);
    tick();
    chk("sw_ack", {7'd0, ack_t}, 8'd1);
    chk("sw_valid", {7'd0, out_valid}, 8'd1);
    chk("sw_data", out_data, 8'hA5);
    chk("sw_evt", evt_count, 8'd1);
    tick();
    chk("sw_popped", {7'd0, out_valid}, 8'd0);

    // backpressure, then push/pop at full
    out_ready = 1'b0;
    exp_q.push_back(8'h11);
    exp_q.push_back(8'h22);
    exp_q.push_back(8'h33);
    send(8'h11);
    send(8'h22);
    data_in = 8'h33;
    t_in = ~t_in;
    repeat (6) tick();
    chk("bp_ack_held", {7'd0, ack_t}, {7'd0, ~t_in});
    chk("bp_head", out_data, 8'h11);
    chk("bp_evt", evt_count, 8'd3);
    out_ready = 1'b1;
    tick();
    chk("pp_ack", {7'd0, ack_t}, {7'd0, t_in});
    chk("pp_valid", {7'd0, out_valid}, 8'd1);
    chk("pp_head", out_data, 8'h22);
    chk("pp_evt", evt_count, 8'd4);
    tick();
    chk("pp_tail", out_data, 8'h33);
    repeat (2) tick();
    chk("bp_drained", {7'd0, out_valid}, 8'd0);
    chk("bp_q_empty", 8'(exp_q.size()), 8'd0);

    // double toggle while full
    out_ready = 1'b0;
    exp_q.push_back(8'h44);
    exp_q.push_back(8'h55);
    send(8'h44);
    send(8'h55);
    chk("ov_pre", {7'd0, overrun}, 8'd0);
    t_prev = t_in;
    data_in = 8'h66;
    t_in = ~t_in;
    repeat (LAT + 2) tick();
    t_in = t_prev;
    repeat (LAT + 2) tick();
    chk("ov_flag", {7'd0, overrun}, 8'd1);
    chk("ov_evt", evt_count, 8'd6);
    chk("ov_ack", {7'd0, ack_t}, {7'd0, t_in});
    out_ready = 1'b1;
    repeat (4) tick();
    chk("ov_drained", {7'd0, out_valid}, 8'd0);
    chk("ov_q_empty", 8'(exp_q.size()), 8'd0);
    chk("ov_sticky", {7'd0, overrun}, 8'd1);

    // counter wrap after reset
    do_reset();
    chk("rr_ovr", {7'd0, overrun}, 8'd0);
    out_ready = 1'b1;
    for (int i = 0; i < 256; i++) begin
      exp_q.push_back(8'(i * 7 + 3));
      send(8'(i * 7 + 3));
      if (i == 254)
        chk("wrap_255", evt_count, 8'd255);
    end
    chk("wrap_0", evt_count, 8'd0);
    repeat (3) tick();
    chk("wrap_q_empty", 8'(exp_q.size()), 8'd0);

    // asynchronous reset between edges
    out_ready = 1'b0;
    send(8'h77);
    chk("ar_valid_pre", {7'd0, out_valid}, 8'd1);
    #3;
    rst_n = 1'b0;
    #1;
    chk("ar_ack", {7'd0, ack_t}, 8'd0);
    chk("ar_valid", {7'd0, out_valid}, 8'd0);
    chk("ar_data", out_data, 8'h00);
    chk("ar_evt", evt_count, 8'h00);
    chk("ar_ovr", {7'd0, overrun}, 8'd0);
    exp_q.delete();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
